// File: rtl/movegen_sequencer.sv
// Move-generation sequencer: streams a 64-square board into the square array,
// then scans own pieces one at a time and emits their (from, to) move pairs.
module movegen_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        start_wtp,
    input  logic [3:0]  start_castle,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [3:0]  ld_data,
    output logic        pos_valid,
    output logic [3:0]  pos_data,
    output logic        wtp,
    output logic [3:0]  castle_rights,
    output logic [63:0] emit_move,
    input  logic [63:0] target_square,
    output logic        mv_valid,
    input  logic        mv_ready,
    output logic [5:0]  mv_from,
    output logic [5:0]  mv_to,
    output logic        busy,
    output logic        done,
    output logic [7:0]  mv_count
);

    localparam int unsigned NSQ  = 64;
    localparam int unsigned SQW  = 6;
    localparam int unsigned NIBW = 4;
    localparam int unsigned CNTW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SELECT,
        S_CAPTURE,
        S_EMIT,
        S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [NSQ-1:0]    own_q, own_d;
    logic [NSQ-1:0]    tgt_q, tgt_d;
    logic [SQW-1:0]    beat_q, beat_d;
    logic [SQW-1:0]    src_q, src_d;
    logic              wtp_q, wtp_d;
    logic [NIBW-1:0]   castle_q, castle_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [SQW-1:0]    tgt_lsb;

    // Index of the lowest set bit; the descending scan lets the lowest hit win.
    function automatic logic [SQW-1:0] lowest_idx(input logic [NSQ-1:0] v);
        lowest_idx = '0;
        for (int i = int'(NSQ) - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = SQW'(i);
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            own_q    <= '0;
            tgt_q    <= '0;
            beat_q   <= '0;
            src_q    <= '0;
            wtp_q    <= 1'b0;
            castle_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            tgt_q    <= tgt_d;
            beat_q   <= beat_d;
            src_q    <= src_d;
            wtp_q    <= wtp_d;
            castle_q <= castle_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        tgt_d     = tgt_q;
        beat_d    = beat_q;
        src_d     = src_q;
        wtp_d     = wtp_q;
        castle_d  = castle_q;
        cnt_d     = cnt_q;
        ld_ready  = 1'b0;
        pos_valid = 1'b0;
        pos_data  = '0;
        emit_move = '0;
        mv_valid  = 1'b0;
        mv_from   = '0;
        mv_to     = '0;
        tgt_lsb   = lowest_idx(tgt_q);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    wtp_d    = start_wtp;
                    castle_d = start_castle;
                    own_d    = '0;
                    tgt_d    = '0;
                    beat_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    pos_valid = 1'b1;
                    pos_data  = ld_data;
                    // Beats arrive h8 first, so beat k lands on square 63-k.
                    if ((ld_data[2:0] != 3'd0) && (ld_data[3] == wtp_q)) begin
                        own_d[~beat_q] = 1'b1;
                    end
                    beat_d = beat_q + SQW'(1);
                    if (beat_q == SQW'(NSQ - 1)) state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (own_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    src_d   = lowest_idx(own_q);
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                emit_move[src_q] = 1'b1;
                tgt_d            = target_square;
                own_d[src_q]     = 1'b0;
                state_d          = S_EMIT;
            end
            S_EMIT: begin
                if (tgt_q == '0) begin
                    state_d = S_SELECT;
                end else begin
                    mv_valid = 1'b1;
                    mv_from  = src_q;
                    mv_to    = tgt_lsb;
                    if (mv_ready) begin
                        tgt_d[tgt_lsb] = 1'b0;
                        if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + CNTW'(1);
                        if (tgt_d == '0) state_d = S_SELECT;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);
    assign wtp           = wtp_q;
    assign castle_rights = castle_q;
    assign mv_count      = cnt_q;

endmodule
